// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Pure declarations: no logic, no latency.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        RD_DATA = 2'd3
    } state_e;

endpackage

// File: rtl/ram_arbiter2_if.sv
// Requester-side and RAM-side bundles of the arbiter.
// Requester holds req/we/addr/wdata until it sees ack; rvalid is a one-cycle pulse.
interface ram_arbiter2_if #(
    parameter int ADDR_W = ram_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = ram_arb_pkg::DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

interface ram_arbiter2_ram_if #(
    parameter int ADDR_W = ram_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = ram_arb_pkg::DATA_W_DEF
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              we;
    logic [DATA_W-1:0] dout;

    modport master (output addr, din, we, input dout);
    modport slave  (input addr, din, we, output dout);
endinterface

// File: rtl/ram_arbiter2_rr_select2.sv
// Combinational two-way winner select; round-robin on last_grant, or fixed port-0
// priority when RAM_ARB_FIXED_PRIO_EN is defined. Zero latency, no backpressure.
module rr_select2
    import ram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic vld_o,
    output logic grant_o
);

    assign vld_o = req0_i | req1_i;

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign grant_o = req0_i ? PORT0 : PORT1;
`else
    always_comb begin
        grant_o = PORT0;
        if (req0_i && req1_i) begin
            grant_o = ~last_grant_i;
        end else if (req1_i) begin
            grant_o = PORT1;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter2.sv
// Serialises two requesters onto one synchronous single-port RAM (RAM_ARB_FIXED_PRIO_EN selects fixed priority).
// ack one cycle after req; write 2 cycles, read data 3 cycles; losers wait with req held.
module ram_arbiter2
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    ram_arbiter2_if.slave      req0_if,
    ram_arbiter2_if.slave      req1_if,
    ram_arbiter2_ram_if.master ram_if
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic sel_vld;
    logic sel_port;

    rr_select2 u_sel (
        .req0_i       (req0_if.req),
        .req1_i       (req1_if.req),
        .last_grant_i (last_grant_q),
        .vld_o        (sel_vld),
        .grant_o      (sel_port)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_we_d     = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    grant_d      = sel_port;
                    last_grant_d = sel_port;
                    ack0_d       = (sel_port == PORT0);
                    ack1_d       = (sel_port == PORT1);
                    if (sel_port == PORT1) begin
                        ram_addr_d = req1_if.addr;
                        ram_din_d  = req1_if.wdata;
                        ram_we_d   = req1_if.we;
                        state_d    = req1_if.we ? WRITE : READ;
                    end else begin
                        ram_addr_d = req0_if.addr;
                        ram_din_d  = req0_if.wdata;
                        ram_we_d   = req0_if.we;
                        state_d    = req0_if.we ? WRITE : READ;
                    end
                end
            end
            WRITE: state_d = IDLE;
            READ:  state_d = RD_DATA;
            // RAM output reflects the address registered during READ.
            RD_DATA: begin
                if (grant_q == PORT1) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = ram_if.dout;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = ram_if.dout;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            grant_q      <= PORT0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_we_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_we_q     <= ram_we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign req0_if.ack    = ack0_q;
    assign req0_if.rvalid = rvalid0_q;
    assign req0_if.rdata  = rdata0_q;
    assign req1_if.ack    = ack1_q;
    assign req1_if.rvalid = rvalid1_q;
    assign req1_if.rdata  = rdata1_q;
    assign ram_if.addr    = ram_addr_q;
    assign ram_if.din     = ram_din_q;
    assign ram_if.we      = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Bench for ram_arbiter2: vector table plus hand sequences, with a RAM model and
// per-port write/read scoreboards checked whenever the DUT writes or returns data.
module tb_ram_arbiter2;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter2_if     r0 ();
    ram_arbiter2_if     r1 ();
    ram_arbiter2_ram_if rm ();

    ram_arbiter2 #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0_if (r0),
        .req1_if (r1),
        .ram_if  (rm)
    );

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (rm.we === 1'b1) mem[rm.addr] <= rm.din;
        rm.dout <= mem[rm.addr];
    end

    int errors = 0;
    int checks = 0;

    logic [23:0] wq0[$], wq1[$];
    logic [7:0]  rq0[$], rq1[$];
    int          glog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (rm.we === 1'b1) begin
            if (r1.ack === 1'b1) begin
                if (wq1.size() == 0) fail("wr1_unexpected");
                else chk("wr1_addr_data", {8'h0, rm.addr, rm.din}, {8'h0, wq1.pop_front()});
            end else if (r0.ack === 1'b1) begin
                if (wq0.size() == 0) fail("wr0_unexpected");
                else chk("wr0_addr_data", {8'h0, rm.addr, rm.din}, {8'h0, wq0.pop_front()});
            end else begin
                fail("we_without_ack");
            end
        end
        if (r0.rvalid === 1'b1) begin
            if (rq0.size() == 0) fail("rvalid0_unexpected");
            else chk("rdata0", {24'h0, r0.rdata}, {24'h0, rq0.pop_front()});
        end
        if (r1.rvalid === 1'b1) begin
            if (rq1.size() == 0) fail("rvalid1_unexpected");
            else chk("rdata1", {24'h0, r1.rdata}, {24'h0, rq1.pop_front()});
        end
        if (r0.rvalid === 1'b1 && r1.rvalid === 1'b1) fail("rvalid_both");
        if (r0.ack === 1'b1) glog.push_back(0);
        if (r1.ack === 1'b1) glog.push_back(1);
    end

    function automatic logic ack_of(input int p);
        return (p == 0) ? r0.ack : r1.ack;
    endfunction

    function automatic logic rv_of(input int p);
        return (p == 0) ? r0.rvalid : r1.rvalid;
    endfunction

    function automatic logic [7:0] rd_of(input int p);
        return (p == 0) ? r0.rdata : r1.rdata;
    endfunction

    // Called at a negedge; returns at the negedge where ack was seen, req dropped.
    task automatic issue(input int p, input logic we, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] exp, output int lat);
        if (p == 0) begin
            r0.req = 1'b1; r0.we = we; r0.addr = a; r0.wdata = d;
            if (we) wq0.push_back({a, d}); else rq0.push_back(exp);
        end else begin
            r1.req = 1'b1; r1.we = we; r1.addr = a; r1.wdata = d;
            if (we) wq1.push_back({a, d}); else rq1.push_back(exp);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack_of(p) !== 1'b1 && lat < 40);
        if (ack_of(p) !== 1'b1) fail("ack_timeout");
        if (p == 0) r0.req = 1'b0; else r1.req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int         port;
        logic       we;
        logic [15:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] last_rd[2];
    int         exp_rr[6];
    int         exp_fp[5];
    logic [15:0] ra0[3], ra1[3];
    logic [7:0]  re0[3], re1[3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0c, a1c, p, o;
        tbl[0] = '{0, 1'b1, 16'h800F, 8'h05, 8'h00};
        tbl[1] = '{0, 1'b0, 16'h800F, 8'h00, 8'h05};
        tbl[2] = '{1, 1'b1, 16'h1234, 8'h3C, 8'h00};
        tbl[3] = '{0, 1'b0, 16'h1234, 8'h00, 8'h3C};
        tbl[4] = '{1, 1'b1, 16'hFFFF, 8'h5A, 8'h00};
        tbl[5] = '{1, 1'b0, 16'hFFFF, 8'h00, 8'h5A};
        tbl[6] = '{0, 1'b1, 16'h0000, 8'hC3, 8'h00};
        tbl[7] = '{1, 1'b0, 16'h0000, 8'h00, 8'hC3};

        r0.req = 0; r0.we = 0; r0.addr = 0; r0.wdata = 0;
        r1.req = 0; r1.we = 0; r1.addr = 0; r1.wdata = 0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack0", {31'h0, r0.ack}, 0);
        chk("rst_ack1", {31'h0, r1.ack}, 0);
        chk("rst_rvalid0", {31'h0, r0.rvalid}, 0);
        chk("rst_rvalid1", {31'h0, r1.rvalid}, 0);
        chk("rst_rdata0", {24'h0, r0.rdata}, 0);
        chk("rst_rdata1", {24'h0, r1.rdata}, 0);
        chk("rst_ram_addr", {16'h0, rm.addr}, 0);
        chk("rst_ram_din", {24'h0, rm.din}, 0);
        chk("rst_ram_we", {31'h0, rm.we}, 0);
        rst = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;

        // Single-requester vectors: latency, pulse width, data isolation.
        for (int i = 0; i < 8; i++) begin
            p = tbl[i].port;
            o = 1 - p;
            issue(p, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, lat);
            chk("ack_latency", lat, 1);
            if (tbl[i].we) begin
                chk("we_pulse", {31'h0, rm.we}, 1);
                chk("we_addr", {16'h0, rm.addr}, {16'h0, tbl[i].addr});
                @(negedge clk);
                chk("we_one_cycle", {31'h0, rm.we}, 0);
            end else begin
                chk("rd_no_we", {31'h0, rm.we}, 0);
                @(negedge clk);
                chk("rv_not_early", {31'h0, rv_of(p)}, 0);
                @(negedge clk);
                chk("rv_latency", {31'h0, rv_of(p)}, 1);
                last_rd[p] = tbl[i].exp;
                chk("other_rdata_hold", {24'h0, rd_of(o)}, {24'h0, last_rd[o]});
                chk("other_rv_quiet", {31'h0, rv_of(o)}, 0);
                @(negedge clk);
                chk("rv_one_cycle", {31'h0, rv_of(p)}, 0);
                chk("rdata_hold", {24'h0, rd_of(p)}, {24'h0, tbl[i].exp});
            end
        end

        // Simultaneous writes right after reset: port 0 first, port 1 two cycles later.
        do_reset();
        r0.req = 1; r0.we = 1; r0.addr = 16'h8000; r0.wdata = 8'h0F;
        r1.req = 1; r1.we = 1; r1.addr = 16'h8001; r1.wdata = 8'hA5;
        wq0.push_back({16'h8000, 8'h0F});
        wq1.push_back({16'h8001, 8'hA5});
        a0c = 0; a1c = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (r0.ack === 1'b1 && a0c == 0) begin a0c = c; r0.req = 0; end
            if (r1.ack === 1'b1 && a1c == 0) begin a1c = c; r1.req = 0; end
        end
        chk("tie_ack0_cycle", a0c, 1);
        chk("tie_ack1_cycle", a1c, 3);
        chk("mem_8000", {24'h0, mem[16'h8000]}, 32'h0F);
        chk("mem_8001", {24'h0, mem[16'h8001]}, 32'hA5);

        // Continuous reads from both ports.
        ra0[0] = 16'h800F; ra0[1] = 16'h0000; ra0[2] = 16'h8000;
        re0[0] = 8'h05;    re0[1] = 8'hC3;    re0[2] = 8'h0F;
        ra1[0] = 16'h1234; ra1[1] = 16'hFFFF; ra1[2] = 16'h8001;
        re1[0] = 8'h3C;    re1[1] = 8'h5A;    re1[2] = 8'hA5;
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_rr = '{0, 0, 0, 1, 1, 1};
        exp_fp = '{0, 0, 0, 0, 1};
`else
        exp_rr = '{0, 1, 0, 1, 0, 1};
        exp_fp = '{0, 1, 0, 0, 0};
`endif
        do_reset();
        glog.delete();
        fork
            begin
                int l0;
                for (int k = 0; k < 3; k++) issue(0, 1'b0, ra0[k], 8'h00, re0[k], l0);
            end
            begin
                int l1;
                for (int k = 0; k < 3; k++) issue(1, 1'b0, ra1[k], 8'h00, re1[k], l1);
            end
        join
        repeat (6) @(negedge clk);
        chk("rr_grant_count", glog.size(), 6);
        for (int k = 0; k < 6 && k < glog.size(); k++) chk("rr_grant_order", glog[k], exp_rr[k]);
        chk("rr_rq0_drained", rq0.size(), 0);
        chk("rr_rq1_drained", rq1.size(), 0);

        // Continuous writes from port 0 against one pending port-1 write.
        do_reset();
        glog.delete();
        fork
            begin
                int l0;
                for (int k = 0; k < 4; k++)
                    issue(0, 1'b1, 16'h3000 + 16'(k), 8'h10 + 8'(k), 8'h00, l0);
            end
            begin
                int l1;
                issue(1, 1'b1, 16'h3100, 8'hEE, 8'h00, l1);
            end
        join
        repeat (4) @(negedge clk);
        chk("prio_grant_count", glog.size(), 5);
        for (int k = 0; k < 5 && k < glog.size(); k++) chk("prio_grant_order", glog[k], exp_fp[k]);
        chk("prio_wq0_drained", wq0.size(), 0);
        chk("prio_wq1_drained", wq1.size(), 0);
        chk("mem_3100", {24'h0, mem[16'h3100]}, 32'hEE);

        // Reset during RD_DATA: the read is discarded.
        issue(0, 1'b0, 16'h800F, 8'h00, 8'h05, lat);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rvalid0", {31'h0, r0.rvalid}, 0);
        chk("rst_mid_rdata0", {24'h0, r0.rdata}, 0);
        chk("rst_mid_ram_we", {31'h0, rm.we}, 0);
        chk("rst_mid_ack0", {31'h0, r0.ack}, 0);
        rst = 1'b0;
        rq0.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_rvalid0", {31'h0, r0.rvalid}, 0);
        end
        issue(0, 1'b1, 16'h4444, 8'h77, 8'h00, lat);
        chk("rst_mid_idle_ack", lat, 1);
        @(negedge clk);
        chk("rst_mid_rdata0_kept", {24'h0, r0.rdata}, 0);
        repeat (2) @(negedge clk);
        chk("mem_4444", {24'h0, mem[16'h4444]}, 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter2.md
Name: ram_arbiter2

Overview:
- Two-requester arbiter and sequencer for the single-port ram_block: 16-bit address, 8-bit data, write enable, synchronous read.
- Accepts read/write transactions from two independent masters and serialises them onto the one RAM port.
- Default scheme: round-robin fairness.
- Drives ram_block address/data_in/we; returns read data to the issuing master with a valid pulse.

Parameters:
ADDR_W, 16, address width of requester and RAM ports
DATA_W, 8, data width of requester and RAM ports

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  port-0 transaction request, held until ack0
we0  in  1  port-0 1=write, 0=read
addr0  in  ADDR_W  port-0 address
wdata0  in  DATA_W  port-0 write data
ack0  out  1  port-0 request accepted (1-cycle pulse)
rvalid0  out  1  port-0 read data valid (1-cycle pulse)
rdata0  out  DATA_W  port-0 read data
req1/we1/addr1/wdata1/ack1/rvalid1/rdata1  same as port 0, for port 1
ram_addr  out  ADDR_W  to ram_block address
ram_din  out  DATA_W  to ram_block data_in
ram_we  out  1  to ram_block we
ram_dout  in  DATA_W  from ram_block data_out; valid one cycle after address with we=0

Behaviour:
- All outputs are registered.
- Reset values: ack*=0, rvalid*=0, rdata*=0, ram_addr=0, ram_din=0, ram_we=0, state=IDLE, last_grant=1 (port 0 wins the first tie).
- FSM states: IDLE, WRITE, READ, RD_DATA.
- IDLE:
  - no req: stay.
  - single req: grant it.
  - both req: grant the port != last_grant.
  - At the granting edge, latch the winner's addr/wdata into ram_addr/ram_din, set ack<winner>=1 and last_grant=winner.
  - Go to WRITE if we=1 (ram_we=1), else READ (ram_we=0).
- WRITE: ram_we high for exactly this one cycle, ack high. Next edge: ram_we=0, ack=0, go to IDLE.
- READ: ram_addr held, ack high. RAM samples the address at the end of this cycle. Next edge: ack=0, go to RD_DATA.
- RD_DATA: ram_dout is valid. Next edge: rdata<winner>=ram_dout, rvalid<winner>=1 for one cycle, go to IDLE.
- Latency, with req sampled at edge E0:
  - ack high during E0..E1.
  - Write performed at edge E1.
  - Read: rvalid high during E2..E3, rdata stable from E2.
  - Throughput: 2 cycles per write, 3 per read.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it samples ack=1.
  - On the cycle after ack it may drop req or present a new transaction.
  - The FSM is never in IDLE while ack is high, so no double-issue.
- A req arriving during a busy state waits; it is never dropped.
- rdataN holds its value until that port's next read completes.
- ram_we is 0 in every state except WRITE.
- Addresses pass through unchanged; 0xFFFF is legal and there is no wrap logic.
- Reset mid-operation: next edge forces IDLE and the reset values. Any in-flight read is discarded (no rvalid). An in-flight write already presented during WRITE may complete at the reset edge; none starts after.
- Simultaneous req0 and req1 exactly as the RR transition (round-robin grant) completes: the loser is served next, after the current transaction returns to IDLE.

Optional Feature:
RAM_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins when both request; last_grant is unused. Port 1 may starve under continuous port-0 traffic.
- Undefined (default): round-robin as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package ram_arb_pkg holds:
  - state encoding (IDLE, WRITE, READ, RD_DATA, 2-bit);
  - port-id constants PORT0=0, PORT1=1;
  - default ADDR_W/DATA_W constants.
- One natural sub-module: rr_select2. Combinational winner select from req0, req1 and last_grant, with the fixed-priority variant under the macro. The pointer register stays in ram_arbiter2.

Test Plan:
- Port 0 writes 0x05 to 0x800F, then reads 0x800F -> ram_we pulses one cycle with ram_addr=0x800F and ram_din=0x05; rvalid0 pulses 3 cycles after the read req; rdata0=0x05.
- First cycle after reset, req0 writes 0x0F to 0x8000 and req1 writes 0xA5 to 0x8001 simultaneously -> ack0 first, ack1 two cycles later; RAM[0x8000]=0x0F, RAM[0x8001]=0xA5.
- Both ports hold continuous reads for 6 transactions -> grant order 0,1,0,1,0,1; rvalid never on both ports in the same cycle.
- Port 1 writes 0x3C to 0x1234, then port 0 reads 0x1234 -> rdata0=0x3C with rvalid0; rvalid1 and rdata1 unchanged.
- rst asserted during RD_DATA of a port-0 read -> next cycle state=IDLE, rvalid0 never pulses, rdata0=0x00, ram_we=0.
- With RAM_ARB_FIXED_PRIO_EN: both hold continuous writes for 4 transactions -> all four granted to port 0, ack1 stays 0 until req0 drops.
